io_input_ctrl: RTL and testbench
================================

Name: io_input_ctrl

Overview:
Debounce and change-detect controller that sits between two raw 32-bit input ports (switches/keys) and the CPU's I/O read path.
- Synchronises each port and samples it on a prescaled tick.
- Commits a new value only after it has been stable for DEB_TICKS consecutive ticks.
- Flags committed changes in a status word and raises irq.
- The CPU reads the stable values and the status word through the existing addr[7:2] I/O decode.

Parameters:
SAMPLE_DIV, 4, io_clk cycles per sample tick (>=2)
DEB_TICKS, 3, consecutive equal samples required to commit (>=2)

Ports:
io_clk  input  1  I/O clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
addr  input  32  CPU address; addr[7:2] selects register
io_rd  input  1  CPU read strobe, one io_clk cycle, qualifies status clear
in_port0  input  32  raw port 0
in_port1  input  32  raw port 1
io_read_data  output  32  selected register, combinational from addr[7:2]
irq  output  1  registered, =chg0|chg1

Behaviour:
- One clock, io_clk; reset synchronous and active-high, sampled on rising edge of io_clk. Reset mid-operation overrides all updates that cycle.
- Reset values:
  - sync stages = 0, stable0/stable1 = 0, cand0/cand1 = 0.
  - deb counters = 0, FSMs = STABLE, prescaler = 0.
  - chg0/chg1 = 0, irq = 0.
  - io_read_data = 0 while reset asserted and for any unmapped addr.
- Synchroniser: two flops per port, updated every cycle; syncN = second stage. Raw-to-syncN latency = 2 cycles.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1, wraps to 0.
  - tick=1 in the cycle prescaler==SAMPLE_DIV-1. First tick after reset is cycle SAMPLE_DIV-1 (counting from the first cycle after reset deasserts as cycle 0).
  - Counter width = clog2(SAMPLE_DIV).
- Per-port FSM (identical, independent). State changes only when tick=1; otherwise all FSM regs hold.
  - STABLE:
    - If syncN==stableN: stay.
    - Else: candN<=syncN, cnt<=1, go PENDING.
  - PENDING, case syncN==candN:
    - If cnt+1==DEB_TICKS: stableN<=candN, set chgN, cnt<=0, go STABLE.
    - Else: cnt<=cnt+1.
  - PENDING, case syncN!=candN:
    - If syncN==stableN: cnt<=0, go STABLE (bounce rejected, no flag).
    - Else: candN<=syncN, cnt<=1, stay PENDING.
  - Commit therefore occurs on the (DEB_TICKS-1)th tick after the tick that entered PENDING.
  - cnt width = clog2(DEB_TICKS+1), never exceeds DEB_TICKS-1.
- Register map (addr[7:2]):
  - 6'b100000: stable0
  - 6'b100001: stable1
  - 6'b100010: status {30'b0, chg1, chg0}
  - anything else: 32'h0
- Status clear:
  - io_rd=1 with addr[7:2]==6'b100010 clears chg0 and chg1 on the next edge. Data returned that cycle is the pre-clear value.
  - Same-cycle commit and clear on a port: set wins, flag stays 1.
  - Reads of other addresses have no side effects.
- irq: registered, =1 the cycle after either chg bit is 1; drops the cycle after both are 0.
- Both ports may commit on the same tick; both flags set.

Test Plan:
All scenarios use SAMPLE_DIV=4, DEB_TICKS=3.
1. Reset held 3 cycles with in_port0=32'hFFFF_FFFF -> after release, io_read_data at addr 0x80 =0, status =0, irq=0 until the debounce completes.
2. in_port0 steps 0->32'h0000_00A5 and holds -> stable0 reads 32'h0000_00A5 and chg0=1 exactly on the 3rd tick after syncN changes; irq=1 one cycle later; stable1 stays 0.
3. in_port1 glitches 0->32'h1 for 5 cycles, then back to 0 -> PENDING exits to STABLE; stable1=0, chg1=0, irq never asserts.
4. in_port1 0->32'h3->32'h7, with the second step one tick after the first -> candidate restarts; stable1=32'h7 committed 2 ticks after the 32'h7 sample; 32'h3 never visible at addr 0x84.
5. Status read (addr=0x88, io_rd=1) with chg0=1 -> returns 32'h1; next cycle status=0; irq=0 one cycle after that. Repeat with a commit on the same edge -> flag stays 1.
6. Both ports change to 32'hDEAD_BEEF / 32'h1234_5678 in the same cycle -> both commit on the same tick; status=32'h3; unmapped addr 0x8C reads 32'h0.

Source files
------------

// File: rtl/io_input_ctrl.sv
// ---------------------------------------------------------------------------
// io_input_ctrl
//
// Debounce and change-detect front end for two raw 32-bit input ports
// (switches/keys) feeding the CPU I/O read path.
//
// Each port is synchronised through two flops and sampled on a prescaled
// tick. A new value is committed to the port's stable register only after
// DEB_TICKS consecutive equal samples. A commit sets a sticky change flag in
// the status word. The CPU clears the flags by reading the status register.
//
// Ports:
//   io_clk       in   1  I/O clock; all state updates on its rising edge
//   reset        in   1  synchronous, active-high reset
//   addr         in  32  CPU address; only addr[7:2] is decoded
//   io_rd        in   1  one-cycle read strobe; qualifies the status clear
//   in_port0     in  32  raw port 0
//   in_port1     in  32  raw port 1
//   io_read_data out 32  selected register (combinational from addr[7:2])
//   irq          out  1  registered OR of the two change flags
//
// Register map (addr[7:2]):
//   6'b100000  stable0
//   6'b100001  stable1
//   6'b100010  status {30'b0, chg1, chg0}
//   others     32'h0
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// io_input_deb
//
// Per-port debounce FSM. Holds the committed (stable) value and the current
// candidate, and counts how many ticks the candidate has been seen.
//
// Ports:
//   clk_i      in   1  clock
//   reset_i    in   1  synchronous, active-high reset
//   tick_i     in   1  sample tick; the FSM only moves when this is high
//   sync_i     in   W  synchronised port value
//   stable_o   out  W  committed value
//   commit_o   out  1  high in the cycle whose edge commits a new value
// ---------------------------------------------------------------------------
module io_input_deb #(
  parameter int unsigned W         = 32,
  parameter int unsigned DEB_TICKS = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         tick_i,
  input  logic [W-1:0] sync_i,
  output logic [W-1:0] stable_o,
  output logic         commit_o
);

  // Wide enough to hold DEB_TICKS itself for the cnt+1 comparison.
  localparam int unsigned CW = $clog2(DEB_TICKS + 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    stable_q, stable_d;
  logic [W-1:0]    cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            commit_s;

  // State and datapath registers of the debounce FSM.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_STABLE;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; everything holds between ticks.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    if (tick_i) begin
      case (state_q)
        ST_STABLE: begin
          if (sync_i != stable_q) begin
            cand_d  = sync_i;
            cnt_d   = CW'(1);
            state_d = ST_PENDING;
          end else begin
            state_d = ST_STABLE;
          end
        end
        ST_PENDING: begin
          if (sync_i == cand_q) begin
            // The entering tick counted as the first equal sample.
            if ((cnt_q + CW'(1)) == CW'(DEB_TICKS)) begin
              stable_d = cand_q;
              commit_s = 1'b1;
              cnt_d    = '0;
              state_d  = ST_STABLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (sync_i == stable_q) begin
            // Input bounced back to the committed value: drop silently.
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            // A different new value restarts the candidate.
            cand_d = sync_i;
            cnt_d  = CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign stable_o = stable_q;
  assign commit_o = commit_s;

endmodule

module io_input_ctrl #(
  parameter int unsigned SAMPLE_DIV = 4,
  parameter int unsigned DEB_TICKS  = 3
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        io_rd,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] io_read_data,
  output logic        irq
);

  localparam int unsigned PW = $clog2(SAMPLE_DIV);

  localparam logic [5:0] A_STABLE0 = 6'b100000;
  localparam logic [5:0] A_STABLE1 = 6'b100001;
  localparam logic [5:0] A_STATUS  = 6'b100010;

  logic [31:0]   sync0_1_q, sync0_2_q;
  logic [31:0]   sync1_1_q, sync1_2_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_s;
  logic [31:0]   stable0_s, stable1_s;
  logic          commit0_s, commit1_s;
  logic          chg0_q, chg0_d;
  logic          chg1_q, chg1_d;
  logic          irq_q, irq_d;
  logic          clr_s;
  logic          addr_unused_s;

  // Only addr[7:2] takes part in the decode.
  assign addr_unused_s = ^{addr[31:8], addr[1:0]};

  // Two-flop synchronisers for both raw ports.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      sync0_1_q <= 32'h0;
      sync0_2_q <= 32'h0;
      sync1_1_q <= 32'h0;
      sync1_2_q <= 32'h0;
    end else begin
      sync0_1_q <= in_port0;
      sync0_2_q <= sync0_1_q;
      sync1_1_q <= in_port1;
      sync1_2_q <= sync1_2_q ^ sync1_2_q ^ sync1_1_q;
    end
  end

  // Sample-tick prescaler next state: count 0..SAMPLE_DIV-1 and wrap.
  always_comb begin
    tick_s = (presc_q == PW'(SAMPLE_DIV - 1));
    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  io_input_deb #(
    .W         (32),
    .DEB_TICKS (DEB_TICKS)
  ) u_deb0 (
    .clk_i    (io_clk),
    .reset_i  (reset),
    .tick_i   (tick_s),
    .sync_i   (sync0_2_q),
    .stable_o (stable0_s),
    .commit_o (commit0_s)
  );

  io_input_deb #(
    .W         (32),
    .DEB_TICKS (DEB_TICKS)
  ) u_deb1 (
    .clk_i    (io_clk),
    .reset_i  (reset),
    .tick_i   (tick_s),
    .sync_i   (sync1_2_q),
    .stable_o (stable1_s),
    .commit_o (commit1_s)
  );

  // Sticky change flags; a commit on the clearing edge keeps its flag set.
  always_comb begin
    clr_s  = io_rd & (addr[7:2] == A_STATUS);
    chg0_d = commit0_s | (chg0_q & ~clr_s);
    chg1_d = commit1_s | (chg1_q & ~clr_s);
    irq_d  = chg0_q | chg1_q;
  end

  // Change flag and interrupt registers.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      chg0_q <= 1'b0;
      chg1_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      chg0_q <= chg0_d;
      chg1_q <= chg1_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;

  // Read mux; forced to zero while reset is asserted.
  always_comb begin
    io_read_data = 32'h0;
    if (reset) begin
      io_read_data = 32'h0;
    end else begin
      case (addr[7:2])
        A_STABLE0: io_read_data = stable0_s;
        A_STABLE1: io_read_data = stable1_s;
        A_STATUS:  io_read_data = {30'h0, chg1_q, chg0_q};
        default:   io_read_data = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench for io_input_ctrl (SAMPLE_DIV=4, DEB_TICKS=3).
// Cycle n is the interval after the n-th rising edge following reset
// release (cycle 0 follows the last edge that sampled reset high).
// Sample ticks occur in cycles 3,7,11,...; FSM updates appear one cycle later.
module tb_io_input_ctrl;

  logic        io_clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        io_rd;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic [31:0] io_read_data;
  logic        irq;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  io_input_ctrl #(
    .SAMPLE_DIV (4),
    .DEB_TICKS  (3)
  ) dut (
    .io_clk       (io_clk),
    .reset        (reset),
    .addr         (addr),
    .io_rd        (io_rd),
    .in_port0     (in_port0),
    .in_port1     (in_port1),
    .io_read_data (io_read_data),
    .irq          (irq)
  );

  always #5 io_clk = ~io_clk;

  // Monitor: one expected entry is consumed per presented read.
  always @(negedge io_clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (io_read_data !== e.data || irq !== e.irq) begin
        failures++;
        $display("FAIL %s: addr=%h got data=%h irq=%b, expected data=%h irq=%b",
                 e.name, e.addr, io_read_data, irq, e.data, e.irq);
      end
    end
  end

  task automatic step();
    @(posedge io_clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic rd_at(input int n, input logic [31:0] a, input logic rd,
                       input logic [31:0] d, input logic i, input string nm);
    goto(n);
    addr  = a;
    io_rd = rd;
    exp_q.push_back('{addr: a, data: d, irq: i, name: nm});
    step();
    io_rd = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    addr     = 32'h80;
    io_rd    = 1'b0;
    in_port0 = 32'hFFFF_FFFF;
    in_port1 = 32'h0;
    // Test 1: reset held three edges with port0 all ones.
    rd_at(0, 32'h80, 1'b0, 32'h0, 1'b0, "in_reset_rd");
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
    rd_at(0,  32'h80, 1'b0, 32'h0,         1'b0, "t1_stable0_after_rst");
    rd_at(1,  32'h88, 1'b0, 32'h0,         1'b0, "t1_status_after_rst");
    rd_at(11, 32'h80, 1'b0, 32'h0,         1'b0, "t1_before_commit");
    rd_at(12, 32'h88, 1'b0, 32'h1,         1'b0, "t1_chg0_set");
    rd_at(13, 32'h80, 1'b0, 32'hFFFF_FFFF, 1'b1, "t1_stable0_ones");
    // Test 5a: status clear; also return port0 to zero.
    goto(14);
    in_port0 = 32'h0;
    rd_at(14, 32'h88, 1'b1, 32'h1,         1'b1, "t5_clear_read");
    rd_at(15, 32'h88, 1'b0, 32'h0,         1'b1, "t5_status_cleared");
    rd_at(16, 32'h80, 1'b0, 32'hFFFF_FFFF, 1'b0, "t5_irq_dropped");
    rd_at(28, 32'h88, 1'b0, 32'h1,         1'b0, "t1_zero_commit");
    rd_at(30, 32'h88, 1'b1, 32'h1,         1'b1, "t1_zero_clear");
    rd_at(31, 32'h88, 1'b0, 32'h0,         1'b1, "t1_zero_cleared");
    // Test 2: port0 0 -> A5.
    goto(32);
    in_port0 = 32'h0000_00A5;
    rd_at(32, 32'h80, 1'b0, 32'h0,         1'b0, "t2_start");
    rd_at(43, 32'h80, 1'b0, 32'h0,         1'b0, "t2_before_3rd_tick");
    rd_at(44, 32'h80, 1'b0, 32'h0000_00A5, 1'b0, "t2_commit");
    rd_at(45, 32'h88, 1'b0, 32'h1,         1'b1, "t2_irq");
    rd_at(46, 32'h84, 1'b0, 32'h0,         1'b1, "t2_stable1_zero");
    rd_at(47, 32'h88, 1'b1, 32'h1,         1'b1, "t2_clear");
    rd_at(48, 32'h88, 1'b0, 32'h0,         1'b1, "t2_cleared");
    rd_at(49, 32'h80, 1'b0, 32'h0000_00A5, 1'b0, "t2_irq_low");
    // Test 3: port1 glitch for five cycles.
    goto(50);
    in_port1 = 32'h1;
    goto(55);
    in_port1 = 32'h0;
    rd_at(57, 32'h88, 1'b0, 32'h0,         1'b0, "t3_pending_status");
    rd_at(60, 32'h84, 1'b0, 32'h0,         1'b0, "t3_stable1");
    rd_at(61, 32'h88, 1'b0, 32'h0,         1'b0, "t3_no_flag");
    // Test 4: port1 0 -> 3 -> 7, with a clear on the commit edge.
    goto(64);
    in_port1 = 32'h3;
    goto(68);
    in_port1 = 32'h7;
    rd_at(72, 32'h84, 1'b0, 32'h0,         1'b0, "t4_no_3_a");
    rd_at(76, 32'h84, 1'b0, 32'h0,         1'b0, "t4_no_3_b");
    rd_at(79, 32'h88, 1'b1, 32'h0,         1'b0, "t4_clear_on_commit");
    rd_at(80, 32'h84, 1'b0, 32'h7,         1'b0, "t4_commit_7");
    rd_at(81, 32'h88, 1'b0, 32'h2,         1'b1, "t4_set_wins");
    rd_at(82, 32'h88, 1'b1, 32'h2,         1'b1, "t4_clear");
    rd_at(83, 32'h88, 1'b0, 32'h0,         1'b1, "t4_cleared");
    rd_at(84, 32'h88, 1'b0, 32'h0,         1'b0, "t4_irq_low");
    // Test 6: both ports change together.
    goto(88);
    in_port0 = 32'hDEAD_BEEF;
    in_port1 = 32'h1234_5678;
    rd_at(99,  32'h88, 1'b0, 32'h0,         1'b0, "t6_before_commit");
    rd_at(100, 32'h88, 1'b0, 32'h3,         1'b0, "t6_both_flags");
    rd_at(101, 32'h80, 1'b0, 32'hDEAD_BEEF, 1'b1, "t6_stable0");
    rd_at(102, 32'h84, 1'b0, 32'h1234_5678, 1'b1, "t6_stable1");
    rd_at(103, 32'h8C, 1'b0, 32'h0,         1'b1, "t6_unmapped_8c");
    rd_at(104, 32'h80, 1'b1, 32'hDEAD_BEEF, 1'b1, "t6_rd_other_addr");
    rd_at(105, 32'h88, 1'b0, 32'h3,         1'b1, "t6_no_side_effect");
    rd_at(106, 32'h00, 1'b0, 32'h0,         1'b1, "t6_unmapped_00");
    // Reset mid-operation.
    goto(107);
    reset = 1'b1;
    rd_at(107, 32'h80, 1'b0, 32'h0,         1'b1, "mid_rst_gated");
    rd_at(108, 32'h88, 1'b0, 32'h0,         1'b0, "mid_rst_applied");
    reset = 1'b0;
    rd_at(109, 32'h80, 1'b0, 32'h0,         1'b0, "mid_rst_stable0");
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) step();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
